// File: rtl/reduce_minmax_int_nbit.sv
// Streaming signed min/max reduction: tracks the running best element of a
// valid/ready stream and emits value, index and count as one held result beat.
module reduce_minmax_int_nbit #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_value,
    output logic [IDX_W-1:0] out_index,
    output logic [IDX_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_t;

    localparam logic [IDX_W-1:0] POS_MAX = '1;
    localparam logic [IDX_W-1:0] POS_ONE = IDX_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] best_q, best_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic [IDX_W-1:0] pos_q, pos_d;
    logic             mode_q, mode_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] out_value_q, out_value_d;
    logic [IDX_W-1:0] out_index_q, out_index_d;
    logic [IDX_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    // Strict signed less-than: differing signs decide by a's sign bit,
    // otherwise the magnitude bits compare as unsigned.
    function automatic logic slt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (a[WIDTH-1] != b[WIDTH-1]) begin
            return a[WIDTH-1];
        end
        return (a[WIDTH-2:0] < b[WIDTH-2:0]);
    endfunction

    logic             accept;
    logic             replace;
    logic             pos_sat;
    logic [IDX_W-1:0] pos_inc;
    logic [WIDTH-1:0] acc_best;
    logic [IDX_W-1:0] acc_idx;
    logic             acc_ovf;

    // Outcome of the current element against the running best (ACCUM rules).
    always_comb begin
        replace  = mode_q ? slt(best_q, in_data) : slt(in_data, best_q);
        pos_sat  = (pos_q == POS_MAX);
        pos_inc  = pos_sat ? pos_q : (pos_q + POS_ONE);
        acc_best = replace ? in_data : best_q;
        acc_idx  = replace ? pos_q : best_idx_q;
        acc_ovf  = ovf_q | pos_sat;
    end

    assign in_ready  = (state_q != S_HOLD);
    assign out_valid = (state_q == S_HOLD);
    assign accept    = in_valid && in_ready;

    assign out_value = out_value_q;
    assign out_index = out_index_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

    // Next-state and datapath updates for the IDLE/ACCUM/HOLD controller.
    always_comb begin
        state_d     = state_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        pos_d       = pos_q;
        mode_d      = mode_q;
        ovf_d       = ovf_q;
        out_value_d = out_value_q;
        out_index_d = out_index_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    best_d     = in_data;
                    best_idx_d = '0;
                    pos_d      = POS_ONE;
                    mode_d     = mode;
                    ovf_d      = 1'b0;
                    if (in_last) begin
                        out_value_d = in_data;
                        out_index_d = '0;
                        out_count_d = POS_ONE;
                        out_ovf_d   = 1'b0;
                        state_d     = S_HOLD;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    best_d     = acc_best;
                    best_idx_d = acc_idx;
                    pos_d      = pos_inc;
                    ovf_d      = acc_ovf;
                    if (in_last) begin
                        out_value_d = acc_best;
                        out_index_d = acc_idx;
                        out_count_d = pos_inc;
                        out_ovf_d   = acc_ovf;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any partial or held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            best_q      <= '0;
            best_idx_q  <= '0;
            pos_q       <= '0;
            mode_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_value_q <= '0;
            out_index_q <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            pos_q       <= pos_d;
            mode_q      <= mode_d;
            ovf_q       <= ovf_d;
            out_value_q <= out_value_d;
            out_index_q <= out_index_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_reduce_minmax_int_nbit.sv
// Bench for reduce_minmax_int_nbit: two instances (IDX_W=16 and IDX_W=2) share
// one stimulus stream; results are compared against a queue-based model.
module tb_reduce_minmax_int_nbit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       mode;
    logic       out_ready;

    logic        a_in_ready, a_out_valid, a_out_ovf;
    logic [7:0]  a_out_value;
    logic [15:0] a_out_index, a_out_count;

    logic        b_in_ready, b_out_valid, b_out_ovf;
    logic [7:0]  b_out_value;
    logic [1:0]  b_out_index, b_out_count;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [7:0] q[$];
    bit         q_mode;

    always #5 clk = ~clk;

    reduce_minmax_int_nbit #(.WIDTH(8), .IDX_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .in_last(in_last), .mode(mode),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_value(a_out_value), .out_index(a_out_index),
        .out_count(a_out_count), .out_ovf(a_out_ovf)
    );

    reduce_minmax_int_nbit #(.WIDTH(8), .IDX_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .in_last(in_last), .mode(mode),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_value(b_out_value), .out_index(b_out_index),
        .out_count(b_out_count), .out_ovf(b_out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: earliest strict min/max over the stream, index and count
    // clipped to the largest value an idxw-bit field holds.
    task automatic model(input int idxw, output int value, output int index,
                         output int count, output int ovf);
        int lim, bv, bi, v, n;
        lim = (1 << idxw) - 1;
        n   = q.size();
        bv  = $signed(q[0]);
        bi  = 0;
        for (int i = 1; i < n; i++) begin
            v = $signed(q[i]);
            if (q_mode ? (v > bv) : (v < bv)) begin
                bv = v;
                bi = i;
            end
        end
        value = bv & 32'hFF;
        index = (bi > lim) ? lim : bi;
        count = (n > lim) ? lim : n;
        ovf   = (n > lim) ? 1 : 0;
    endtask

    // Sends q; mode is only meaningful on the first element, later ones
    // optionally scramble it. Idle gaps drive stray in_last without in_valid.
    task automatic send_stream(input bit with_last, input bit scramble);
        int  guard;
        bit  accepted;
        for (int i = 0; i < q.size(); i++) begin
            if (scramble) begin
                int gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) begin
                    in_valid = 1'b0;
                    in_last  = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_data  = q[i];
            in_last  = with_last && (i == q.size() - 1);
            mode     = (i == 0) ? q_mode : (scramble ? 1'($urandom_range(0, 1)) : q_mode);
            guard    = 0;
            do begin
                accepted = a_in_ready;
                @(posedge clk); #1;
                guard++;
            end while (!accepted && guard < 20);
            if (!accepted) check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic check_result(input string tag);
        int v, ix, c, o;
        check({tag, "_a_valid"}, a_out_valid, 1);
        check({tag, "_a_ready"}, a_in_ready, 0);
        model(16, v, ix, c, o);
        check({tag, "_a_value"}, a_out_value, v);
        check({tag, "_a_index"}, a_out_index, ix);
        check({tag, "_a_count"}, a_out_count, c);
        check({tag, "_a_ovf"},   a_out_ovf, o);
        model(2, v, ix, c, o);
        check({tag, "_b_valid"}, b_out_valid, 1);
        check({tag, "_b_value"}, b_out_value, v);
        check({tag, "_b_index"}, b_out_index, ix);
        check({tag, "_b_count"}, b_out_count, c);
        check({tag, "_b_ovf"},   b_out_ovf, o);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_rel_valid"}, a_out_valid, 0);
        check({tag, "_rel_ready"}, a_in_ready, 1);
        check({tag, "_rel_b_valid"}, b_out_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        mode = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_value", a_out_value, 0);
        check("rst_index", a_out_index, 0);
        check("rst_count", a_out_count, 0);
        check("rst_ovf", a_out_ovf, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // min of 5,-3,7,-3: first -3 wins
        q = '{8'h05, 8'hFD, 8'h07, 8'hFD}; q_mode = 1'b0;
        send_stream(1'b1, 1'b0);
        check_result("min4");
        check("min4_value_const", a_out_value, 8'hFD);
        check("min4_index_const", a_out_index, 1);
        check("min4_count_const", a_out_count, 4);
        release_result("min4");

        // max across the sign boundary, tie keeps first 127
        q = '{8'h80, 8'h7F, 8'h00, 8'h7F}; q_mode = 1'b1;
        send_stream(1'b1, 1'b0);
        check_result("max4");
        check("max4_value_const", a_out_value, 8'h7F);
        check("max4_index_const", a_out_index, 1);
        release_result("max4");

        // single element goes straight to HOLD, then backpressure
        q = '{8'h80}; q_mode = 1'b1;
        send_stream(1'b1, 1'b0);
        check_result("single");
        check("single_value_const", a_out_value, 8'h80);
        check("single_count_const", a_out_count, 1);
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            in_data  = 8'h11;
            in_last  = 1'b1;
            @(posedge clk); #1;
            check("bp_ready", a_in_ready, 0);
            check("bp_valid", a_out_valid, 1);
            check("bp_value", a_out_value, 8'h80);
            check("bp_count", a_out_count, 1);
        end
        in_valid = 1'b0; in_last = 1'b0;
        release_result("single");
        q = '{8'h22}; q_mode = 1'b0;
        send_stream(1'b1, 1'b0);
        check_result("fresh");
        check("fresh_value_const", a_out_value, 8'h22);
        release_result("fresh");

        // count saturation on the narrow-index instance
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00}; q_mode = 1'b0;
        send_stream(1'b1, 1'b0);
        check_result("sat");
        check("sat_b_count_const", b_out_count, 3);
        check("sat_b_ovf_const", b_out_ovf, 1);
        check("sat_b_index_const", b_out_index, 3);
        check("sat_b_value_const", b_out_value, 8'h00);
        release_result("sat");

        // reset mid-stream discards the partial result
        q = '{8'h40, 8'hC0}; q_mode = 1'b1;
        send_stream(1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", a_out_valid, 0);
        check("midrst_ready", a_in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        q = '{8'h09}; q_mode = 1'b0;
        send_stream(1'b1, 1'b0);
        check_result("postrst");
        check("postrst_value_const", a_out_value, 8'h09);
        check("postrst_count_const", a_out_count, 1);
        release_result("postrst");

        // randomized streams with gaps and mid-stream mode noise
        for (int s = 0; s < 30; s++) begin
            int len = $urandom_range(1, 8);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
            q_mode = 1'($urandom_range(0, 1));
            send_stream(1'b1, 1'b1);
            check_result("rand");
            release_result("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/reduce_minmax_int_nbit.md
Name: reduce_minmax_int_nbit

Overview:
- Streaming signed-integer min/max reduction stage, directly downstream of the n-bit signed less-than comparator.
- Accepts a stream of WIDTH-bit two's-complement elements over a valid/ready handshake.
- Uses a strict signed less-than between each incoming element and the running best.
- On the element flagged last, emits the winning value, its index and the element count as one registered result beat.

Parameters:
- WIDTH, 32, element width in bits, two's complement; minimum 2.
- IDX_W, 16, width of the index and count outputs.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  element present on in_data.
- in_ready  output  1  stage can accept an element this cycle.
- in_data  input  WIDTH  signed element.
- in_last  input  1  marks final element of the stream; qualified by in_valid.
- mode  input  1  0 = minimum, 1 = maximum; sampled only on the first accepted element of a stream.
- out_valid  output  1  result beat held.
- out_ready  input  1  consumer accepts the result.
- out_value  output  WIDTH  winning element.
- out_index  output  IDX_W  zero-based position of the winner in the stream.
- out_count  output  IDX_W  number of elements accepted.
- out_ovf  output  1  stream exceeded 2^IDX_W-1 elements.

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE.
  - in_ready=1.
  - out_valid=0; out_value, out_index, out_count, out_ovf all 0.
  - Internal best, position and mode registers cleared.
- Handshake: an element is accepted on a clock edge where in_valid && in_ready. The result transfers on out_valid && out_ready.
- FSM states: IDLE, ACCUM, HOLD.
  - IDLE, in_ready=1. On accept: best<=in_data; best_idx<=0; pos<=1; mode_r<=mode; ovf<=0.
    - If in_last=1, go to HOLD.
    - Otherwise go to ACCUM.
  - ACCUM, in_ready=1. On accept:
    - Replace if (mode_r==0 && in_data <s best) or (mode_r==1 && best <s in_data). On replace: best<=in_data, best_idx<=pos.
    - pos<=pos+1, saturating at 2^IDX_W-1. When an increment is blocked by saturation, ovf<=1.
    - If in_last=1, go to HOLD and load the output registers in that same edge, including this element's outcome.
    - A cycle with no accept holds all state.
  - HOLD, in_ready=0, out_valid=1.
    - Outputs are stable until out_ready.
    - On out_valid && out_ready, go to IDLE. in_ready rises the next cycle; there is no same-cycle bypass.
- Latency: out_valid asserts on the cycle after the last element is accepted.
- Signed compare semantics:
  - If the sign bits differ, a<b equals a's sign bit.
  - Otherwise use the unsigned compare of the low WIDTH-1 bits.
- Ties never replace, so the earliest index wins.
- out_count = number of accepted elements (pos at the last accept), saturated.
- out_index is valid even when out_ovf=1, but is clipped to the saturated range.
- mode changes mid-stream are ignored.
- Reset asserted mid-stream or during HOLD discards the partial/held result immediately; no output beat is produced.
- in_last arriving without in_valid has no effect.

Test Plan:
- WIDTH=8, mode=0, stream 5,-3,7,-3(last) -> out_value=-3 (0xFD), out_index=1, out_count=4, out_ovf=0, one cycle after last accept.
- mode=1, stream -128,127,0,127(last) -> out_value=127, out_index=1, out_count=4; checks sign-boundary compare and tie-keeps-first.
- Single-element stream: mode=1, 0x80 with in_last -> HOLD directly; out_value=-128, out_index=0, out_count=1.
- Backpressure: out_ready held 0 for 5 cycles in HOLD -> outputs stable, in_ready=0, in_valid pulses ignored; release -> IDLE, next stream starts fresh.
- IDX_W=2, stream of 5 elements 1,2,3,4,0(last), mode=0 -> out_count=3, out_ovf=1, out_value=0, out_index=3.
- rst_n pulsed low mid-ACCUM after 2 elements -> out_valid=0 and in_ready=1 at once; next stream 9(last) -> out_value=9, out_count=1.
